// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that lets several measurement sources share one byte-wide UART
// transmit engine, sending each granted payload as a framed packet.
module uart_frame_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WORDS   = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         Req_Sig,
  input  logic [NUM_REQ*WORDS*32-1:0] Req_Data,
  output logic [NUM_REQ-1:0]         Req_Ack,
  output logic [NUM_REQ-1:0]         Frame_Done,
  output logic                       Busy,
  output logic [7:0]                 TX_Data,
  output logic                       TX_En_Sig,
  input  logic                       TX_Done_Sig
);

  localparam int FRAME_LEN = 4*WORDS + 4;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PAY_W     = WORDS*32;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [SRC_W-1:0]     rr_q, rr_d;
  logic [PAY_W-1:0]     pay_q, pay_d;
  logic [7:0]           data_q, data_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   fdone_q, fdone_d;
  logic                 gnt_vld;
  logic [SRC_W-1:0]     gnt;

  // Byte idx of the frame: header, payload words MSB byte first, then FF 0D 0A.
  function automatic logic [7:0] frame_byte(input logic [CNT_W-1:0] idx,
                                            input logic [SRC_W-1:0] src,
                                            input logic [PAY_W-1:0] pay);
    int i;
    int w;
    int b;
    i = int'(idx);
    w = (i - 1) / 4;
    b = (i - 1) % 4;
    if (i == 0)
      frame_byte = 8'hA0 | {{(8-SRC_W){1'b0}}, src};
    else if (i <= 4*WORDS)
      frame_byte = pay[w*32 + (3-b)*8 +: 8];
    else if (i == 4*WORDS + 1)
      frame_byte = 8'hFF;
    else if (i == 4*WORDS + 2)
      frame_byte = 8'h0D;
    else
      frame_byte = 8'h0A;
  endfunction

  // First requesting source at or after the round-robin pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && Req_Sig[(int'(rr_q) + i) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt     = SRC_W'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    rr_d    = rr_q;
    pay_d   = pay_q;
    data_d  = data_q;
    en_d    = en_q;
    busy_d  = busy_q;
    ack_d   = '0;
    fdone_d = '0;
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        cnt_d = '0;
        if (gnt_vld) begin
          src_d       = gnt;
          pay_d       = Req_Data[int'(gnt)*PAY_W +: PAY_W];
          ack_d[gnt]  = 1'b1;
          busy_d      = 1'b1;
          data_d      = frame_byte('0, gnt, Req_Data[int'(gnt)*PAY_W +: PAY_W]);
          state_d     = SEND;
        end
      end
      SEND: begin
        // A done pulse only counts once the enable has actually been presented.
        if (en_q && TX_Done_Sig) begin
          en_d = 1'b0;
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            fdone_d[src_q] = 1'b1;
            state_d        = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = GAP;
          end
        end else begin
          en_d = 1'b1;
        end
      end
      GAP: begin
        en_d    = 1'b0;
        data_d  = frame_byte(cnt_q, src_q, pay_q);
        state_d = SEND;
      end
      DONE: begin
        busy_d  = 1'b0;
        rr_d    = (src_q == SRC_W'(NUM_REQ - 1)) ? '0 : src_q + SRC_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      rr_q    <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      fdone_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      fdone_q <= fdone_d;
    end
  end

  // Payload snapshot is pure data and needs no reset.
  always_ff @(posedge CLK) begin
    pay_q <= pay_d;
  end

  assign Req_Ack    = ack_q;
  assign Frame_Done = fdone_q;
  assign Busy       = busy_q;
  assign TX_Data    = data_q;
  assign TX_En_Sig  = en_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: table of single-frame transactions plus
// hand-written reset, round-robin and spurious-done sequences against an engine model.
module tb_uart_frame_arbiter;

  logic         CLK;
  logic         RST;
  logic [1:0]   Req_Sig;
  logic [255:0] Req_Data;
  logic [1:0]   Req_Ack;
  logic [1:0]   Frame_Done;
  logic         Busy;
  logic [7:0]   TX_Data;
  logic         TX_En_Sig;
  logic         TX_Done_Sig;

  logic         tx_done;
  logic         spur;
  assign TX_Done_Sig = tx_done | spur;

  uart_frame_arbiter #(.NUM_REQ(2), .WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .Req_Sig(Req_Sig), .Req_Data(Req_Data),
    .Req_Ack(Req_Ack), .Frame_Done(Frame_Done), .Busy(Busy),
    .TX_Data(TX_Data), .TX_En_Sig(TX_En_Sig), .TX_Done_Sig(TX_Done_Sig)
  );

  typedef struct {
    logic [1:0]   req;
    logic [127:0] pay0;
    logic [127:0] pay1;
    int           lat;
    logic [1:0]   exp_ack;
    logic [7:0]   exp_hdr;
  } vec_t;

  vec_t       vecs[6];
  int         n_vec;
  int         n_fail;
  int         lat_cfg;
  int         stab_err;
  int         gap_err;
  int         multi_err;
  int         ack_cnt;
  int         fdone_cnt;
  logic [7:0] byte_q[$];
  logic [7:0] hdr_q[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Engine model: raises a one-cycle done lat_cfg cycles after seeing enable.
  initial begin
    int  wcnt;
    logic prev_en;
    logic [7:0] held;
    tx_done = 1'b0;
    wcnt    = 0;
    prev_en = 1'b0;
    held    = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST) begin
        tx_done = 1'b0;
        wcnt    = 0;
        prev_en = 1'b0;
      end else if (tx_done) begin
        tx_done = 1'b0;
        if (TX_En_Sig) gap_err++;
        prev_en = 1'b0;
      end else if (TX_En_Sig) begin
        if (prev_en && TX_Data !== held) stab_err++;
        held    = TX_Data;
        prev_en = 1'b1;
        if (wcnt >= lat_cfg) begin
          tx_done = 1'b1;
          byte_q.push_back(TX_Data);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        prev_en = 1'b0;
        wcnt    = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (Req_Ack != 2'b00) begin
        ack_cnt++;
        hdr_q.push_back(TX_Data);
        if ($countones(Req_Ack) > 1) multi_err++;
      end
      if (Frame_Done != 2'b00) fdone_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int i, input logic [7:0] hdr, input logic [127:0] pay);
    logic [127:0] t;
    t = pay >> (((i - 1) / 4) * 32);
    if (i == 0)       return hdr;
    else if (i <= 16) return t[31 - ((i - 1) % 4) * 8 -: 8];
    else if (i == 17) return 8'hFF;
    else if (i == 18) return 8'h0D;
    else              return 8'h0A;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc;
    logic [127:0] pay;
    logic [7:0] b;
    pay     = v.exp_ack[1] ? v.pay1 : v.pay0;
    lat_cfg = v.lat;
    byte_q.delete();
    Req_Data = {v.pay1, v.pay0};
    Req_Sig  = v.req;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (Req_Ack == 2'b00 && cyc < 20);
    chk("ack_latency", 32'(cyc), 32'd1);
    chk("ack_vector", 32'(Req_Ack), 32'(v.exp_ack));
    chk("header_loaded", 32'(TX_Data), 32'(v.exp_hdr));
    chk("busy_at_ack", 32'(Busy), 32'd1);
    chk("en_low_at_ack", 32'(TX_En_Sig), 32'd0);
    Req_Sig  = 2'b00;
    Req_Data = ~Req_Data;
    @(negedge CLK);
    chk("en_rise", 32'(TX_En_Sig), 32'd1);
    cyc = 0;
    while (Frame_Done == 2'b00 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    chk("frame_done", 32'(Frame_Done), 32'(v.exp_ack));
    chk("busy_at_done", 32'(Busy), 32'd1);
    chk("byte_count", 32'(byte_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      b = (i < byte_q.size()) ? byte_q[i] : 8'h5A;
      chk($sformatf("byte%0d", i), 32'(b), 32'(ref_byte(i, v.exp_hdr, pay)));
    end
    @(negedge CLK);
    chk("busy_clear", 32'(Busy), 32'd0);
    chk("done_pulse_width", 32'(Frame_Done), 32'd0);
  endtask

  initial begin
    int cyc;
    int fd0;
    int a0;
    vec_t sv;
    n_vec = 0; n_fail = 0; stab_err = 0; gap_err = 0; multi_err = 0;
    ack_cnt = 0; fdone_cnt = 0; lat_cfg = 0;
    spur = 1'b0;

    vecs[0] = '{2'b01, {32'hDEADBEEF, 32'h0, 32'h0, 32'h12345678}, 128'h0, 2, 2'b01, 8'hA0};
    vecs[1] = '{2'b10, 128'h0, 128'h0A0B0C0D_11223344_55667788_99AABBCC, 10, 2'b10, 8'hA1};
    vecs[2] = '{2'b11, 128'hCAFEF00D_01020304_A5A5A5A5_80000001, 128'h1, 1, 2'b01, 8'hA0};
    vecs[3] = '{2'b11, 128'h0, 128'hFFFFFFFF_00000000_7F7F7F7F_13579BDF, 0, 2'b10, 8'hA1};
    vecs[4] = '{2'b10, 128'h0, {4{32'hFFFFFFFF}}, 3, 2'b10, 8'hA1};
    vecs[5] = '{2'b11, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 128'h0, 0, 2'b01, 8'hA0};

    RST = 1'b1; Req_Sig = 2'b00; Req_Data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ack", 32'(Req_Ack), 32'd0);
    chk("rst_fdone", 32'(Frame_Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_en", 32'(TX_En_Sig), 32'd0);
    chk("rst_data", 32'(TX_Data), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a frame.
    lat_cfg  = 3;
    Req_Data = {128'h0, 128'h11111111_22222222_33333333_44444444};
    Req_Sig  = 2'b01;
    cyc = 0;
    do begin @(negedge CLK); cyc++; end while (Req_Ack == 2'b00 && cyc < 20);
    chk("midrst_ack", 32'(Req_Ack), 32'd1);
    Req_Sig = 2'b00;
    repeat (30) @(negedge CLK);
    chk("midrst_en_before", 32'(Busy), 32'd1);
    fd0 = fdone_cnt;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_en", 32'(TX_En_Sig), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_data", 32'(TX_Data), 32'd0);
    chk("midrst_ack0", 32'(Req_Ack), 32'd0);
    chk("midrst_fdone", 32'(Frame_Done), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    chk("midrst_no_done", 32'(fdone_cnt), 32'(fd0));
    chk("midrst_idle", 32'(TX_En_Sig), 32'd0);

    // Both sources held: alternation starts from source 0 after reset.
    lat_cfg = 0;
    hdr_q.delete();
    a0 = ack_cnt;
    Req_Sig = 2'b11;
    cyc = 0;
    while (ack_cnt < a0 + 3 && cyc < 3000) begin @(negedge CLK); cyc++; end
    Req_Sig = 2'b00;
    chk("rr_acks", 32'(ack_cnt - a0), 32'd3);
    chk("rr_hdr0", 32'(hdr_q.size() > 0 ? hdr_q[0] : 8'h00), 32'hA0);
    chk("rr_hdr1", 32'(hdr_q.size() > 1 ? hdr_q[1] : 8'h00), 32'hA1);
    chk("rr_hdr2", 32'(hdr_q.size() > 2 ? hdr_q[2] : 8'h00), 32'hA0);
    cyc = 0;
    while (Busy && cyc < 1000) begin @(negedge CLK); cyc++; end
    chk("rr_drain", 32'(Busy), 32'd0);
    repeat (2) @(negedge CLK);

    // Spurious done while idle, then a source-1 frame.
    spur = 1'b1;
    @(negedge CLK);
    spur = 1'b0;
    @(negedge CLK);
    chk("spur_busy", 32'(Busy), 32'd0);
    chk("spur_en", 32'(TX_En_Sig), 32'd0);
    sv = '{2'b10, 128'h0, 128'h89ABCDEF_76543210_00FF00FF_DEADC0DE, 2, 2'b10, 8'hA1};
    run_vec(sv);

    chk("data_stable_while_en", 32'(stab_err), 32'd0);
    chk("en_low_between_bytes", 32'(gap_err), 32'd0);
    chk("single_ack_per_cycle", 32'(multi_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
